// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter feeding the uart_top TX FIFO write port
//
// Purpose: grants one byte-stream requester at a time for a whole packet
// (delimited by req_last) and forwards its bytes to the TX FIFO while
// tx_full is low. A grant is force-released after MAX_BEATS data bytes.
// Optional feature macro: UART_ARB_TAG_EN (prefix each grant with tag byte
// {4'hF, grant_id}; requires DBIT == 8).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_data/req_last/req_ready   per-requester byte streams
//   tx_full               TX FIFO full
//   wr_uart, w_data       TX FIFO write strobe and data
//   grant_id              current / last granted requester
//   busy                  grant held (state != IDLE)
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DBIT      = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DBIT-1:0]      req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       tx_full,
  output logic                       wr_uart,
  output logic [DBIT-1:0]            w_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, DATA = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_q, beat_d;

  logic [DBIT-1:0] data_arr [N_REQ];
  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   next_ptr;
  logic            sel_valid;
  logic            sel_last;
  logic [DBIT-1:0] sel_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DBIT +: DBIT];
  end

  assign sel_valid = req_valid[grant_id_q];
  assign sel_last  = req_last[grant_id_q];
  assign sel_data  = data_arr[grant_id_q];
  assign next_ptr  = (int'(grant_id_q) == N_REQ - 1) ? '0 : grant_id_q + 1'b1;

  // Rotating priority search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = GW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_d     = beat_q;
    req_ready  = '0;
    wr_uart    = 1'b0;
    w_data     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = pick;
          beat_d     = '0;
`ifdef UART_ARB_TAG_EN
          state_d    = TAG;
`else
          state_d    = DATA;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = DBIT'({4'hF, 4'(grant_id_q)});
          state_d = DATA;
        end
      end
`endif
      DATA: begin
        req_ready[grant_id_q] = !tx_full;
        if (sel_valid && !tx_full) begin
          wr_uart = 1'b1;
          w_data  = sel_data;
          beat_d  = beat_q + 1'b1;
          // End of packet and beat-limit release share one path, so a
          // coincident last + limit advances rr_ptr only once.
          if (sel_last || beat_q == CW'(MAX_BEATS - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_q     <= beat_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule
